// File: rtl/ai_accel_pkg.sv
// ai_accel_pkg: FSM states, CSR bit layout, accumulator width and address-window helpers
package ai_accel_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int CSR_START   = 0;
    localparam int CSR_SIGNED  = 1;
    localparam int CSR_SAT     = 2;
    localparam int CSR_SHIFT   = 4;
    localparam int CSR_SHIFT_W = 5;
    localparam int CSR_CLR_ERR = 9;
    localparam int CSR_DONE    = 16;
    localparam int CSR_ERR     = 17;
    function automatic int acc_width(input int bits, input int n);
        return 2 * bits + $clog2(n);
    endfunction
    function automatic logic in_window(input int a, input int base, input int size);
        return a >= base && a < base + size;
    endfunction
    function automatic int word_index(input int a, input int base, input int word_bytes);
        return (a - base) / word_bytes;
    endfunction
endpackage

// File: rtl/accel_mac_row.sv
// accel_mac_row: N parallel MAC lanes computing one C row, with shift/saturate post-processing
module accel_mac_row
    import ai_accel_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N    = 8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_last,
    input  logic                   i_clr,
    input  logic                   i_signed,
    input  logic                   i_sat,
    input  logic [CSR_SHIFT_W-1:0] i_shift,
    input  logic [BITS-1:0]        i_a,
    input  logic [BITS-1:0]        i_b [N],
    output logic [BITS-1:0]        o_res [N]
);
    localparam int ACC = acc_width(BITS, N);
    localparam logic signed [ACC-1:0] SMAX = ACC'((1 << (BITS - 1)) - 1);
    localparam logic signed [ACC-1:0] SMIN = ACC'(-(1 << (BITS - 1)));
    localparam logic [ACC-1:0]        UMAX = ACC'((1 << BITS) - 1);
    logic signed [BITS:0] w_ae;
    assign w_ae = {i_signed & i_a[BITS-1], i_a};
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic signed [BITS:0]    w_be;
        logic signed [ACC-1:0]   w_prod, w_ssh;
        logic [ACC-1:0]          r_acc, w_sum, w_ush;
        assign w_be   = {i_signed & i_b[j][BITS-1], i_b[j]};
        assign w_prod = ACC'(w_ae) * ACC'(w_be);
        assign w_sum  = r_acc + w_prod;
        // separate signed/unsigned shifts keep the arithmetic shift out of an unsigned context
        assign w_ssh  = $signed(w_sum) >>> i_shift;
        assign w_ush  = w_sum >> i_shift;
        assign o_res[j] = !i_sat ? (i_signed ? w_ssh[BITS-1:0] : w_ush[BITS-1:0])
                        : i_signed ? (w_ssh > SMAX ? SMAX[BITS-1:0] : w_ssh < SMIN ? SMIN[BITS-1:0] : w_ssh[BITS-1:0])
                        : (w_ush > UMAX ? UMAX[BITS-1:0] : w_ush[BITS-1:0]);
        always_ff @(posedge clk)
            if (rst || i_clr) r_acc <= '0;
            else if (i_en) r_acc <= i_last ? '0 : w_sum;
    end
endmodule

// File: rtl/ai_accel_seq.sv
// ai_accel_seq: memory-mapped sequential matrix multiplier with A/B/C windows and a CSR
module ai_accel_seq
    import ai_accel_pkg::*;
#(
    parameter int                    BITS       = 8,
    parameter int                    N          = 8,
    parameter int                    WIDTH      = 4,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] OFFCET     = 10'd128,
    parameter logic [ADDR_WIDTH-1:0] CSR_ADDR   = 10'd124
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    wr_en,
    input  logic [WIDTH*BITS-1:0]   data_in,
    output logic [WIDTH*BITS-1:0]   data_out,
    output logic                    a_stored,
    output logic                    b_stored,
    output logic                    c_show,
    output logic                    busy,
    output logic                    done
);
    localparam int DW = WIDTH * BITS, WB = DW / 8, MB = N * N * BITS / 8, NW = N * N / WIDTH;
    localparam int A_BASE = int'(OFFCET), B_BASE = A_BASE + MB, C_BASE = B_BASE + MB;
    localparam int EI = $clog2(N * N), WI = $clog2(NW), CW = $clog2(N);
    state_t                 r_state;
    logic [BITS-1:0]        r_a [N*N];
    logic [BITS-1:0]        r_b [N*N];
    logic [BITS-1:0]        r_c [N*N];
    logic [NW-1:0]          r_av, r_bv;
    logic [CW-1:0]          r_i, r_k;
    logic                   r_signed, r_sat, r_done, r_done_st, r_err;
    logic [CSR_SHIFT_W-1:0] r_shift;
    logic [DW-1:0]          r_dout, w_rd, w_csr;
    logic                   w_in_a, w_in_b, w_csr_sel, w_start, w_clr_err, w_last;
    logic [WI-1:0]          w_wi;
    logic [BITS-1:0]        w_brow [N];
    logic [BITS-1:0]        w_res [N];
    assign w_in_a    = in_window(int'(addr), A_BASE, MB);
    assign w_in_b    = in_window(int'(addr), B_BASE, MB);
    assign c_show    = in_window(int'(addr), C_BASE, MB);
    assign w_csr_sel = addr == CSR_ADDR;
    assign w_wi      = WI'(word_index(int'(addr), w_in_a ? A_BASE : w_in_b ? B_BASE : C_BASE, WB));
    assign w_start   = wr_en && w_csr_sel && data_in[CSR_START] && r_state == IDLE;
    assign w_clr_err = wr_en && w_csr_sel && data_in[CSR_CLR_ERR];
    assign w_last    = r_state == RUN && r_k == CW'(N - 1);
    assign busy      = r_state == RUN;
    assign done      = r_done;
    assign a_stored  = &r_av;
    assign b_stored  = &r_bv;
    assign data_out  = r_dout;
    assign w_csr     = DW'({r_err, r_done_st, 7'b0, r_shift, 1'b0, r_sat, r_signed, busy});
    always_comb begin
        w_rd = '0;
        for (int e = 0; e < WIDTH; e++)
            w_rd[e*BITS +: BITS] = w_in_a ? r_a[EI'(w_wi * WIDTH + e)] : w_in_b ? r_b[EI'(w_wi * WIDTH + e)]
                                 : c_show ? r_c[EI'(w_wi * WIDTH + e)] : '0;
        if (w_csr_sel) w_rd = w_csr;
    end
    for (genvar j = 0; j < N; j++) begin : g_brow
        assign w_brow[j] = r_b[EI'(r_k * N + j)];
    end
    // mode/shift registers only change while idle, so they double as the per-run latched mode
    accel_mac_row #(.BITS(BITS), .N(N)) u_mac (
        .clk(clk), .rst(rst), .i_en(busy), .i_last(w_last), .i_clr(w_start),
        .i_signed(r_signed), .i_sat(r_sat), .i_shift(r_shift),
        .i_a(r_a[EI'(r_i * N + r_k)]), .i_b(w_brow), .o_res(w_res)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_i       <= '0;
            r_k       <= '0;
            r_av      <= '0;
            r_bv      <= '0;
            r_signed  <= 1'b0;
            r_sat     <= 1'b0;
            r_shift   <= '0;
            r_done    <= 1'b0;
            r_done_st <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= '0;
            for (int e = 0; e < N * N; e++) begin
                r_a[e] <= '0;
                r_b[e] <= '0;
                r_c[e] <= '0;
            end
        end else begin
            r_dout <= w_rd;
            r_done <= w_last && r_i == CW'(N - 1);
            r_err  <= (r_err && !w_clr_err) || (wr_en && busy && (w_in_a || w_in_b));
            if (wr_en && !busy && w_in_a) begin
                r_av[w_wi] <= 1'b1;
                for (int e = 0; e < WIDTH; e++) r_a[EI'(w_wi * WIDTH + e)] <= data_in[e*BITS +: BITS];
            end
            if (wr_en && !busy && w_in_b) begin
                r_bv[w_wi] <= 1'b1;
                for (int e = 0; e < WIDTH; e++) r_b[EI'(w_wi * WIDTH + e)] <= data_in[e*BITS +: BITS];
            end
            if (wr_en && w_csr_sel && !busy) begin
                r_signed <= data_in[CSR_SIGNED];
                r_sat    <= data_in[CSR_SAT];
                r_shift  <= data_in[CSR_SHIFT +: CSR_SHIFT_W];
            end
            if (w_start) begin
                r_state   <= RUN;
                r_i       <= '0;
                r_k       <= '0;
                r_done_st <= 1'b0;
            end
            if (busy) begin
                r_k <= w_last ? '0 : r_k + 1'b1;
                if (w_last) begin
                    for (int j = 0; j < N; j++) r_c[EI'(r_i * N + j)] <= w_res[j];
                    r_i <= r_i + 1'b1;
                    if (r_i == CW'(N - 1)) begin
                        r_state   <= IDLE;
                        r_done_st <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
